multicycle_control: RTL and testbench

- Multi-cycle sequencer for the 16-bit core. Steps each instruction through fetch, decode, execute, memory and writeback.
- Consumes opcode and type flags decoded from the instruction register. Drives the PC, IR, register-file, ALU-source and memory-interface enables.
- Sits between the instruction decoder outputs and the datapath muxes, one instruction in flight at a time.

---
 rtl/multicycle_control_if.sv | 43 ++++
 rtl/multicycle_control.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
// Bundles the decoder flags, the memory handshake and the datapath enables
// that pass between the multi-cycle sequencer and the rest of the 16-bit core.
// master: the sequencer (drives enables, samples decoder/memory status).
// slave : the datapath/decoder side (drives status, samples enables).
interface multicycle_control_if;
   // Decoder and datapath status into the sequencer
   logic [3:0] opcode;
   logic       is_r_type;
   logic       is_j_type;
   logic       alu_zero;
   logic       mem_ready;

   // Memory interface and datapath enables out of the sequencer
   logic       mem_req;
   logic       mem_we;
   logic       addr_sel;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       alu_src;
   logic       reg_write;
   logic [1:0] reg_dst;
   logic       mem_to_reg;
   logic       instr_retired;
   logic       halted;
   logic       fault;
   logic [2:0] state;

   modport master (
      input  opcode, is_r_type, is_j_type, alu_zero, mem_ready,
      output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
             alu_src, reg_write, reg_dst, mem_to_reg, instr_retired,
             halted, fault, state
   );

   modport slave (
      output opcode, is_r_type, is_j_type, alu_zero, mem_ready,
      input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
             alu_src, reg_write, reg_dst, mem_to_reg, instr_retired,
             halted, fault, state
   );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle sequencer for the 16-bit core: FETCH -> DECODE -> EXEC ->
// MEM -> WB, one instruction in flight. The only register is the state
// (plus the memory wait counter when enabled); every enable is decoded
// combinationally from the current state and the decoder/memory inputs.
// Optional feature: define MULTICYCLE_MEM_TIMEOUT_EN to bound memory waits
// to MEM_TIMEOUT cycles and trap into a sticky FAULT state. Without it the
// waits are unbounded, fault is tied low and FAULT is never entered.
module multicycle_control #(
   parameter logic [3:0] OP_R_TYPE   = 4'h0,
   parameter logic [3:0] OP_LW       = 4'h2,
   parameter logic [3:0] OP_SW       = 4'h3,
   parameter logic [3:0] OP_BEQ      = 4'h4,
   parameter logic [3:0] OP_J        = 4'h8,
   parameter logic [3:0] OP_JAL      = 4'h9,
   parameter logic [3:0] OP_JR       = 4'hA,
   parameter logic [3:0] OP_HALT     = 4'hF,
   parameter int         MEM_TIMEOUT = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   multicycle_control_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_FAULT  = 3'd6,
      S_RESET  = 3'd7
   } state_e;

   localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] PC_SRC_RS     = 2'b11;

   localparam logic [1:0] REG_DST_RD    = 2'b00;
   localparam logic [1:0] REG_DST_RT    = 2'b01;
   localparam logic [1:0] REG_DST_LINK  = 2'b10;

   state_e state_q, state_d;

   // Jump handling is fully determined by the opcode; the decoder's J-type
   // flag is carried on the interface for other consumers only.
   logic unused_is_j_type;
   assign unused_is_j_type = bus.is_j_type;

   // R-type opcode is implied by is_r_type; kept as a parameter for clarity.
   localparam logic [3:0] unused_op_r_type = OP_R_TYPE;

`ifdef MULTICYCLE_MEM_TIMEOUT_EN
   localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_inc;
   logic             tmo_hit;

   // Consecutive-wait count; reaching the limit on this cycle triggers FAULT.
   assign tmo_cnt_inc = tmo_cnt_q + TMO_W'(1);
   assign tmo_hit     = (tmo_cnt_inc == TMO_W'(MEM_TIMEOUT));
`else
   localparam int unused_mem_timeout = MEM_TIMEOUT;
`endif

   // Next-state and all datapath enables, decoded from the current state.
   always_comb begin
      state_d            = state_q;
      bus.mem_req        = 1'b0;
      bus.mem_we         = 1'b0;
      bus.addr_sel       = 1'b0;
      bus.ir_write       = 1'b0;
      bus.pc_write       = 1'b0;
      bus.pc_src         = PC_SRC_SEQ;
      bus.alu_src        = 1'b0;
      bus.reg_write      = 1'b0;
      bus.reg_dst        = REG_DST_RD;
      bus.mem_to_reg     = 1'b0;
      bus.instr_retired  = 1'b0;
      bus.halted         = 1'b0;
      bus.fault          = 1'b0;
`ifdef MULTICYCLE_MEM_TIMEOUT_EN
      // Any cycle that is not a memory wait clears the counter, so every
      // entry into FETCH or MEM starts counting from zero.
      tmo_cnt_d          = '0;
`endif

      case (state_q)
         S_RESET: begin
            state_d = S_FETCH;
         end

         S_FETCH: begin
            // Instruction read at the PC; request held until memory completes.
            bus.mem_req = 1'b1;
            if (bus.mem_ready) begin
               bus.ir_write = 1'b1;
               bus.pc_write = 1'b1;
               bus.pc_src   = PC_SRC_SEQ;
               state_d      = S_DECODE;
            end else begin
`ifdef MULTICYCLE_MEM_TIMEOUT_EN
               tmo_cnt_d = tmo_cnt_inc;
               if (tmo_hit) begin
                  state_d = S_FAULT;
               end
`endif
            end
         end

         S_DECODE: begin
            // Jumps complete here; everything else needs the ALU.
            if (bus.opcode == OP_HALT) begin
               state_d = S_HALT;
            end else if (bus.opcode == OP_J) begin
               bus.pc_write      = 1'b1;
               bus.pc_src        = PC_SRC_JUMP;
               bus.instr_retired = 1'b1;
               state_d           = S_FETCH;
            end else if (bus.opcode == OP_JAL) begin
               bus.pc_write      = 1'b1;
               bus.pc_src        = PC_SRC_JUMP;
               bus.reg_write     = 1'b1;
               bus.reg_dst       = REG_DST_LINK;
               bus.instr_retired = 1'b1;
               state_d           = S_FETCH;
            end else if (bus.opcode == OP_JR) begin
               bus.pc_write      = 1'b1;
               bus.pc_src        = PC_SRC_RS;
               bus.instr_retired = 1'b1;
               state_d           = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            // Register-register compare/ALU for R-type and BEQ, immediate otherwise.
            bus.alu_src = !(bus.is_r_type || (bus.opcode == OP_BEQ));
            if (bus.is_r_type) begin
               state_d = S_WB;
            end else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
               state_d = S_MEM;
            end else if (bus.opcode == OP_BEQ) begin
               bus.instr_retired = 1'b1;
               if (bus.alu_zero) begin
                  bus.pc_write = 1'b1;
                  bus.pc_src   = PC_SRC_BRANCH;
               end
               state_d = S_FETCH;
            end else begin
               // ALU-immediate and unrecognised opcodes write back the ALU result.
               state_d = S_WB;
            end
         end

         S_MEM: begin
            // Data access at the ALU-computed address; the immediate stays
            // selected so the address is stable for the whole wait.
            bus.mem_req  = 1'b1;
            bus.addr_sel = 1'b1;
            bus.alu_src  = 1'b1;
            bus.mem_we   = (bus.opcode == OP_SW);
            if (bus.mem_ready) begin
               if (bus.opcode == OP_SW) begin
                  bus.instr_retired = 1'b1;
                  state_d           = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else begin
`ifdef MULTICYCLE_MEM_TIMEOUT_EN
               tmo_cnt_d = tmo_cnt_inc;
               if (tmo_hit) begin
                  state_d = S_FAULT;
               end
`endif
            end
         end

         S_WB: begin
            bus.reg_write     = 1'b1;
            bus.reg_dst       = bus.is_r_type ? REG_DST_RD : REG_DST_RT;
            bus.mem_to_reg    = (bus.opcode == OP_LW);
            bus.alu_src       = !bus.is_r_type;
            bus.instr_retired = 1'b1;
            state_d           = S_FETCH;
         end

         S_HALT: begin
            // Sticky until reset, all enables quiet.
            bus.halted = 1'b1;
         end

         S_FAULT: begin
`ifdef MULTICYCLE_MEM_TIMEOUT_EN
            bus.fault = 1'b1;
`endif
         end

         default: begin
            state_d = S_RESET;
         end
      endcase
   end

   assign bus.state = state_q;

   // State register (and wait counter); reset forces RESET even mid-access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RESET;
`ifdef MULTICYCLE_MEM_TIMEOUT_EN
         tmo_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
`ifdef MULTICYCLE_MEM_TIMEOUT_EN
         tmo_cnt_q <= tmo_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Scoreboard bench for the multi-cycle sequencer. Each instruction is
// expanded from its class (jump, branch, load, store, ALU, halt) into the
// cycle-by-cycle list of expected control outputs; the driver issues the
// inputs and queues the expectations, and a negedge monitor pops and
// compares one record per clock.
`timescale 1ns/1ps
module tb_multicycle_control;

   localparam logic [3:0] OP_R    = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_LW   = 4'h2;
   localparam logic [3:0] OP_SW   = 4'h3;
   localparam logic [3:0] OP_BEQ  = 4'h4;
   localparam logic [3:0] OP_J    = 4'h8;
   localparam logic [3:0] OP_JAL  = 4'h9;
   localparam logic [3:0] OP_JR   = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef struct packed {
      logic [2:0] state;
      logic       mem_req;
      logic       mem_we;
      logic       addr_sel;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       alu_src;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic       mem_to_reg;
      logic       instr_retired;
      logic       halted;
      logic       fault;
   } outv_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multicycle_control_if bus();

   multicycle_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   outv_t exp_q[$];
   int    checks       = 0;
   int    errors       = 0;
   int    cyc          = 0;
   int    act_retired  = 0;
   int    exp_retired  = 0;
   outv_t mon_e, mon_a;

   function automatic outv_t rec(input logic [2:0] st);
      outv_t r;
      r       = '0;
      r.state = st;
      return r;
   endfunction

   function automatic outv_t sample();
      outv_t a;
      a.state         = bus.state;
      a.mem_req       = bus.mem_req;
      a.mem_we        = bus.mem_we;
      a.addr_sel      = bus.addr_sel;
      a.ir_write      = bus.ir_write;
      a.pc_write      = bus.pc_write;
      a.pc_src        = bus.pc_src;
      a.alu_src       = bus.alu_src;
      a.reg_write     = bus.reg_write;
      a.reg_dst       = bus.reg_dst;
      a.mem_to_reg    = bus.mem_to_reg;
      a.instr_retired = bus.instr_retired;
      a.halted        = bus.halted;
      a.fault         = bus.fault;
      return a;
   endfunction

   // Monitor: one expected record per clock, compared mid-cycle.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.instr_retired === 1'b1) act_retired = act_retired + 1;
      if (exp_q.size() > 0) begin
         mon_e  = exp_q.pop_front();
         mon_a  = sample();
         checks = checks + 1;
         if (mon_a !== mon_e) begin
            errors = errors + 1;
            $display("FAIL ctrl cycle=%0d op=%h state=%0d: got %h required %h",
                     cyc, bus.opcode, mon_a.state, mon_a, mon_e);
         end
      end
   end

   // Drive one clock of inputs and queue what the controller must show.
   task automatic issue(input logic [3:0] op, input bit rdy, input bit z, input outv_t e);
      @(posedge clk);
      #1;
      bus.opcode    = op;
      bus.is_r_type = (op == OP_R);
      bus.is_j_type = (op == OP_J) || (op == OP_JAL) || (op == OP_JR);
      bus.mem_ready = rdy;
      bus.alu_zero  = z;
      exp_q.push_back(e);
   endtask

   // Hold rst_n low for n-1 cycles (asserted asynchronously mid-cycle),
   // releasing it during the last one; state reads 7 throughout.
   task automatic reset_seq(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) rst_n = 1'b0;
         bus.opcode    = 4'($urandom);
         bus.is_r_type = 1'($urandom);
         bus.is_j_type = 1'($urandom);
         bus.mem_ready = 1'($urandom);
         bus.alu_zero  = 1'($urandom);
         if (i == n - 1) rst_n = 1'b1;
         exp_q.push_back(rec(3'd7));
      end
   endtask

   // Expand one instruction into its expected cycle trace and issue it.
   // wf/wm: memory wait cycles in FETCH/MEM; z: alu_zero for BEQ;
   // cut >= 0 stops after that many cycles; hc: cycles to observe HALT.
   task automatic run_instr(input logic [3:0] op, input int wf, input int wm,
                            input bit z, input int cut, input int hc);
      outv_t eq[$];
      bit    rq[$];
      bit    zq[$];
      outv_t r;
      bit    is_r;
      bit    is_jmp;
      int    n;
      is_r   = (op == OP_R);
      is_jmp = (op == OP_J) || (op == OP_JAL) || (op == OP_JR);

      for (int i = 0; i < wf; i++) begin
         r = rec(3'd0); r.mem_req = 1'b1;
         eq.push_back(r); rq.push_back(1'b0); zq.push_back(1'($urandom));
      end
      r = rec(3'd0); r.mem_req = 1'b1; r.ir_write = 1'b1; r.pc_write = 1'b1;
      eq.push_back(r); rq.push_back(1'b1); zq.push_back(1'($urandom));

      r = rec(3'd1);
      if (op == OP_J)   begin r.pc_write = 1'b1; r.pc_src = 2'b10; r.instr_retired = 1'b1; end
      if (op == OP_JAL) begin r.pc_write = 1'b1; r.pc_src = 2'b10; r.instr_retired = 1'b1;
                              r.reg_write = 1'b1; r.reg_dst = 2'b10; end
      if (op == OP_JR)  begin r.pc_write = 1'b1; r.pc_src = 2'b11; r.instr_retired = 1'b1; end
      eq.push_back(r); rq.push_back(1'($urandom)); zq.push_back(1'($urandom));

      if (op == OP_HALT) begin
         for (int i = 0; i < hc; i++) begin
            r = rec(3'd5); r.halted = 1'b1;
            eq.push_back(r); rq.push_back(1'($urandom)); zq.push_back(1'($urandom));
         end
      end else if (!is_jmp) begin
         r = rec(3'd2);
         r.alu_src = !(is_r || (op == OP_BEQ));
         if (op == OP_BEQ) begin
            r.instr_retired = 1'b1;
            r.pc_write      = z;
            r.pc_src        = z ? 2'b01 : 2'b00;
            eq.push_back(r); rq.push_back(1'($urandom)); zq.push_back(z);
         end else begin
            eq.push_back(r); rq.push_back(1'($urandom)); zq.push_back(1'($urandom));
         end
         if ((op == OP_LW) || (op == OP_SW)) begin
            for (int i = 0; i <= wm; i++) begin
               r = rec(3'd3); r.mem_req = 1'b1; r.addr_sel = 1'b1; r.alu_src = 1'b1;
               r.mem_we = (op == OP_SW);
               if ((i == wm) && (op == OP_SW)) r.instr_retired = 1'b1;
               eq.push_back(r); rq.push_back(i == wm); zq.push_back(1'($urandom));
            end
         end
         if ((op != OP_BEQ) && (op != OP_SW)) begin
            r = rec(3'd4); r.reg_write = 1'b1; r.reg_dst = is_r ? 2'b00 : 2'b01;
            r.mem_to_reg = (op == OP_LW); r.alu_src = !is_r; r.instr_retired = 1'b1;
            eq.push_back(r); rq.push_back(1'($urandom)); zq.push_back(1'($urandom));
         end
      end

      n = (cut < 0) ? eq.size() : cut;
      for (int i = 0; i < n; i++) issue(op, rq[i], zq[i], eq[i]);
      if ((cut < 0) && (op != OP_HALT)) exp_retired = exp_retired + 1;
   endtask

`ifdef MULTICYCLE_MEM_TIMEOUT_EN
   // Memory never answers the fetch: 16 waiting cycles, then sticky FAULT.
   task automatic fault_test();
      outv_t r;
      for (int i = 0; i < 16; i++) begin
         r = rec(3'd0); r.mem_req = 1'b1;
         issue(OP_R, 1'b0, 1'($urandom), r);
      end
      for (int i = 0; i < 6; i++) begin
         r = rec(3'd6); r.fault = 1'b1;
         issue(4'($urandom), 1'($urandom), 1'($urandom), r);
      end
   endtask
`endif

   logic [3:0] pool [14] = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL,
                             OP_JR, 4'h5, 4'h7, 4'hB, 4'hE, OP_LW, OP_R};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.opcode    = 4'h0;
      bus.is_r_type = 1'b0;
      bus.is_j_type = 1'b0;
      bus.mem_ready = 1'b0;
      bus.alu_zero  = 1'b0;

      reset_seq(3);

      // Directed: R-type after reset, LW with three data waits, both BEQ
      // outcomes, JAL, long waits, HALT and a reset dropped inside MEM.
      run_instr(OP_R,   0, 0, 1'b0, -1, 0);
      run_instr(OP_LW,  0, 3, 1'b0, -1, 0);
      run_instr(OP_BEQ, 0, 0, 1'b1, -1, 0);
      run_instr(OP_BEQ, 0, 0, 1'b0, -1, 0);
      run_instr(OP_JAL, 0, 0, 1'b0, -1, 0);
      run_instr(OP_J,   1, 0, 1'b0, -1, 0);
      run_instr(OP_JR,  0, 0, 1'b0, -1, 0);
      run_instr(OP_SW,  2, 1, 1'b0, -1, 0);
      run_instr(4'hC,   0, 0, 1'b0, -1, 0);
`ifndef MULTICYCLE_MEM_TIMEOUT_EN
      run_instr(OP_R,  20, 0, 1'b0, -1, 0);
      run_instr(OP_LW,  0, 20, 1'b0, -1, 0);
`endif
      run_instr(OP_HALT, 0, 0, 1'b0, -1, 20);
      reset_seq(3);
      run_instr(OP_SW, 0, 5, 1'b0, 5, 0);
      reset_seq(3);

      // Random instruction mix with random wait states.
      for (int k = 0; k < 60; k++) begin
         run_instr(pool[$urandom_range(0, 13)], $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom), -1, 0);
      end

`ifdef MULTICYCLE_MEM_TIMEOUT_EN
      fault_test();
      reset_seq(3);
      run_instr(OP_R, 0, 0, 1'b0, -1, 0);
`endif

      @(negedge clk);
      #1;
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: got %0d pending records required 0", exp_q.size());
      end
      checks = checks + 1;
      if (act_retired != exp_retired) begin
         errors = errors + 1;
         $display("FAIL retire_count: got %0d required %0d", act_retired, exp_retired);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
